// File: rtl/vec_elem_sequencer.sv
// vec_elem_sequencer: splits a 32-bit vector op into ELEM_W-wide element ops on a shared lane and packs one writeback
module vec_elem_sequencer #(
    parameter int ELEM_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       src1_i,
    input  logic [31:0]       src2_i,
    input  logic [4:0]        rd_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              elem_valid_o,
    input  logic              elem_ready_i,
    output logic [ELEM_W-1:0] elem_a_o,
    output logic [ELEM_W-1:0] elem_b_o,
    output logic [2:0]        elem_op_o,
    input  logic              elem_result_valid_i,
    input  logic [ELEM_W-1:0] elem_result_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o
);
    localparam int NUM_ELEMS = 32 / ELEM_W;
    localparam int IDX_W = NUM_ELEMS > 1 ? $clog2(NUM_ELEMS) : 1;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DRAIN} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [31:0] a_q, b_q, res_q, wb_data_q, a_sh, b_sh;
    logic [2:0] op_q;
    logic [4:0] rd_q, wb_rd_q;
    logic accept, last;
    assign accept = state == IDLE && start_i && !flush_i;
    assign last = 32'(idx) == NUM_ELEMS - 1;
    assign a_sh = a_q >> (32'(idx) * ELEM_W);
    assign b_sh = b_q >> (32'(idx) * ELEM_W);
    assign elem_a_o = a_sh[ELEM_W-1:0];
    assign elem_b_o = b_sh[ELEM_W-1:0];
    assign elem_op_o = op_q;
    always_comb begin
        state_nx = state;
        stall_o = accept || state == ISSUE || state == WAIT || state == DRAIN;
        busy_o = state != IDLE;
        elem_valid_o = state == ISSUE;
        wb_valid_o = state == WRITE;
        wb_rd_o = state == WRITE ? rd_q : wb_rd_q;
        wb_data_o = state == WRITE ? res_q : wb_data_q;
        case (state)
            IDLE:    state_nx = accept ? ISSUE : IDLE;
            ISSUE:   state_nx = elem_ready_i ? (flush_i ? DRAIN : WAIT) : (flush_i ? IDLE : ISSUE);
            WAIT:    state_nx = elem_result_valid_i ? (flush_i ? IDLE : last ? WRITE : ISSUE)
                                                    : (flush_i ? DRAIN : WAIT);
            WRITE:   state_nx = IDLE;
            DRAIN:   state_nx = elem_result_valid_i ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else state <= state_nx;
    end
    // wb_* outputs replay the held copy outside WRITE so they keep their last value
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            op_q <= '0;
            rd_q <= '0;
            wb_data_q <= '0;
            wb_rd_q <= '0;
        end else begin
            if (accept) begin
                a_q <= src1_i;
                b_q <= src2_i;
                op_q <= funct3_i;
                rd_q <= rd_i;
                res_q <= '0;
                idx <= '0;
            end
            if (state == WAIT && elem_result_valid_i && !flush_i) begin
                for (int e = 0; e < NUM_ELEMS; e++)
                    if (32'(idx) == e) res_q[e*ELEM_W +: ELEM_W] <= elem_result_i;
                if (!last) idx <= idx + 1'b1;
            end
            if (state == WRITE) begin
                wb_data_q <= res_q;
                wb_rd_q <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_vec_elem_sequencer.sv
// tb_vec_elem_sequencer: runs every op on 8/16/32-bit instances with a randomized lane and checks against a word-level model
module tb_vec_elem_sequencer;
    logic clk_i = 0, rst_n_i = 0, start_i = 0, flush_i = 0;
    logic [2:0] funct3_i = 0;
    logic [31:0] src1_i = 0, src2_i = 0;
    logic [4:0] rd_i = 0;
    int cyc = 0, ready_gap = 0, res_lat = 1, passed = 0, total = 0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] elem_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        case (f)
            3'd1: return a - b;
            3'd4: return a ^ b;
            3'd6: return a | b;
            3'd7: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_vec(int w, logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [31:0] r, m;
        r = 0;
        m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 1;
        for (int e = 0; e < 32 / w; e++)
            r |= (elem_op(f, (a >> (e * w)) & m, (b >> (e * w)) & m) & m) << (e * w);
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen
        localparam int W = 8 << g;
        logic stall, busy, ev, rdy, rv, wbv, pend, hold, stall_wb;
        logic [W-1:0] ea, eb, res, pa, pb, pval;
        logic [2:0] eop;
        logic [4:0] wrd, cap_rd;
        logic [31:0] wdat, cap_data, lane_val;
        int gap, cnt, st, n_wb, at, nstall, stab;
        vec_elem_sequencer #(.ELEM_W(W)) dut (
            .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
            .funct3_i(funct3_i), .src1_i(src1_i), .src2_i(src2_i), .rd_i(rd_i),
            .stall_o(stall), .busy_o(busy), .elem_valid_o(ev), .elem_ready_i(rdy),
            .elem_a_o(ea), .elem_b_o(eb), .elem_op_o(eop),
            .elem_result_valid_i(rv), .elem_result_i(res),
            .wb_valid_o(wbv), .wb_rd_o(wrd), .wb_data_o(wdat)
        );
        assign rdy = ev && gap >= ready_gap;
        assign lane_val = elem_op(eop, 32'(ea), 32'(eb));
        always @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                gap <= 0; cnt <= 0; pend <= 0; rv <= 0; res <= '0; pval <= '0;
            end else begin
                rv <= 0;
                if (ev && rdy) begin
                    gap <= 0;
                    if (res_lat == 1) begin
                        rv <= 1;
                        res <= lane_val[W-1:0];
                    end else begin
                        pend <= 1;
                        cnt <= res_lat - 1;
                        pval <= lane_val[W-1:0];
                    end
                end else if (ev) gap <= gap + 1;
                if (pend) begin
                    if (cnt == 1) begin
                        rv <= 1;
                        res <= pval;
                        pend <= 0;
                    end else cnt <= cnt - 1;
                end
            end
        end
        always @(negedge clk_i) begin
            if (start_i && !flush_i && !busy) begin
                st = cyc; n_wb = 0; nstall = 0; stab = 0; hold = 0;
            end
            if (stall) nstall++;
            if (hold && ev && (ea !== pa || eb !== pb)) stab++;
            hold = ev && !rdy;
            pa = ea;
            pb = eb;
            if (wbv) begin
                n_wb++;
                at = cyc - st;
                cap_data = wdat;
                cap_rd = wrd;
                stall_wb = stall;
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic launch(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic [4:0] rd);
        @(posedge clk_i); #1;
        src1_i = a; src2_i = b; funct3_i = f; rd_i = rd; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while ((gen[0].busy || gen[1].busy || gen[2].busy) && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk({tag, "_timeout"}, 32'(n >= 500), 0);
        @(negedge clk_i);
    endtask

    task automatic chk_op(string tag, int w, int n_wb, int at, int nstall, int stab, logic stall_wb,
                          logic [31:0] data, logic [4:0] rd, logic [31:0] a, logic [31:0] b,
                          logic [2:0] f, logic [4:0] erd);
        int lat = 1 + (32 / w) * (ready_gap + 1 + res_lat);
        chk({tag, "_wbcount"}, n_wb, 1);
        chk({tag, "_latency"}, at, lat);
        chk({tag, "_stallcycles"}, nstall, lat);
        chk({tag, "_stall_at_wb"}, stall_wb, 0);
        chk({tag, "_operand_stable"}, stab, 0);
        chk({tag, "_data"}, data, ref_vec(w, f, a, b));
        chk({tag, "_rd"}, rd, erd);
    endtask

    task automatic run_all(string tag, logic [31:0] a, logic [31:0] b, logic [2:0] f, logic [4:0] rd);
        launch(a, b, f, rd);
        wait_idle(tag);
        chk_op({tag, "_w8"}, 8, gen[0].n_wb, gen[0].at, gen[0].nstall, gen[0].stab, gen[0].stall_wb,
               gen[0].cap_data, gen[0].cap_rd, a, b, f, rd);
        chk_op({tag, "_w16"}, 16, gen[1].n_wb, gen[1].at, gen[1].nstall, gen[1].stab, gen[1].stall_wb,
               gen[1].cap_data, gen[1].cap_rd, a, b, f, rd);
        chk_op({tag, "_w32"}, 32, gen[2].n_wb, gen[2].at, gen[2].nstall, gen[2].stab, gen[2].stall_wb,
               gen[2].cap_data, gen[2].cap_rd, a, b, f, rd);
    endtask

    initial begin
        logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd7};
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", {gen[0].busy, gen[1].busy, gen[2].busy}, 0);
        chk("rst_stall", {gen[0].stall, gen[1].stall, gen[2].stall}, 0);
        chk("rst_valid", {gen[0].ev, gen[0].wbv}, 0);
        chk("rst_wb", {gen[0].wdat[26:0], gen[0].wrd}, 0);
        rst_n_i = 1;

        run_all("ideal", 32'h0403_0201, 32'h1010_1010, 3'd0, 5'd5);
        chk("ideal_cycle9", gen[0].at, 9);
        chk("ideal_data", gen[0].cap_data, 32'h1413_1211);

        ready_gap = 3; res_lat = 2;
        run_all("slow", 32'h0403_0201, 32'h1010_1010, 3'd0, 5'd5);
        chk("slow_data", gen[0].cap_data, 32'h1413_1211);

        ready_gap = 0; res_lat = 3;
        launch(32'h1122_3344, 32'h0101_0101, 3'd0, 5'd7);
        repeat (9) @(posedge clk_i);
        #1 flush_i = 1;
        @(posedge clk_i); #1 flush_i = 0;
        @(negedge clk_i);
        chk("drain_busy11", gen[0].busy, 1);
        chk("drain_stall11", gen[0].stall, 1);
        @(negedge clk_i);
        chk("drain_busy12", gen[0].busy, 1);
        @(negedge clk_i);
        chk("drain_idle13", gen[0].busy, 0);
        chk("flush_no_wb", gen[0].n_wb, 0);
        wait_idle("flush");
        chk_op("flush_w16", 16, gen[1].n_wb, gen[1].at, gen[1].nstall, gen[1].stab, gen[1].stall_wb,
               gen[1].cap_data, gen[1].cap_rd, 32'h1122_3344, 32'h0101_0101, 3'd0, 5'd7);
        run_all("after_flush", 32'hA0B0_C0D0, 32'h0F0E_0D0C, 3'd4, 5'd12);

        @(posedge clk_i); #1;
        start_i = 1; flush_i = 1;
        @(negedge clk_i);
        chk("startflush_stall", {gen[0].stall, gen[1].stall, gen[2].stall}, 0);
        chk("startflush_valid", {gen[0].ev, gen[1].ev, gen[2].ev}, 0);
        @(posedge clk_i); #1;
        start_i = 0; flush_i = 0;
        @(negedge clk_i);
        chk("startflush_idle", {gen[0].busy, gen[1].busy, gen[2].busy}, 0);

        ready_gap = 3; res_lat = 1;
        launch(32'h8765_4321, 32'h1111_1111, 3'd1, 5'd17);
        repeat (6) @(posedge clk_i);
        #1;
        chk("pre_rst_issue", gen[0].ev, 1);
        rst_n_i = 0;
        #1;
        chk("arst_ctrl", {gen[0].stall, gen[0].busy, gen[0].ev, gen[0].wbv}, 0);
        chk("arst_elem", {gen[0].ea, gen[0].eb, gen[0].eop}, 0);
        chk("arst_wb", {gen[0].wrd, gen[0].wdat}, 0);
        #1 rst_n_i = 1;
        ready_gap = 0;
        run_all("post_rst", 32'h0002_0001, 32'h0003_0003, 3'd0, 5'd9);
        chk("post_rst_w16_cycle5", gen[1].at, 5);
        chk("post_rst_w16_data", gen[1].cap_data, 32'h0005_0004);

        run_all("carry", 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 5'd3);
        chk("carry_w32_data", gen[2].cap_data, 0);
        chk("carry_w32_cycle3", gen[2].at, 3);

        for (int i = 0; i < 20; i++) begin
            ready_gap = $urandom_range(0, 3);
            res_lat = $urandom_range(1, 3);
            run_all($sformatf("rand%0d", i), $urandom, $urandom, ops[$urandom_range(0, 4)],
                    5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
